layer_frames_mux_n: RTL and testbench
=====================================

Name: layer_frames_mux_n

Overview:
- Merges frame streams from NLAYERS layer interfaces into one 8-bit AXI-Stream frame output for the core readout path.
- Arbitrates round-robin at frame granularity; a frame is never interleaved with another.
- Tags each frame with its layer id on tdest.
- Aborts frames whose source stalls beyond a configurable timeout, then discards that layer's remaining beats up to its tlast.

Parameters:
- NLAYERS, 4, number of input layer streams (1..16).
- LAYER_BASE, 0, tdest value for channel 0; channel i outputs LAYER_BASE+i (8-bit, wraps modulo 256).
- TW, 16, width of timeout counter and cfg_timeout.
- ABORT_BYTE, 8'hFF, data value of the synthesized terminator beat on timeout.

Ports:
- clk_core  in  1  core clock; all logic in this domain.
- clk_core_rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NLAYERS*8  per-layer frame data; channel i at [8i+7:8i].
- s_axis_tlast  in  NLAYERS  per-layer end of frame.
- s_axis_tvalid  in  NLAYERS  per-layer valid.
- s_axis_tready  out  NLAYERS  per-layer ready.
- m_axis_tdata  out  8  merged frame data.
- m_axis_tdest  out  8  layer id of the current frame.
- m_axis_tlast  out  1  end of frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- cfg_layer_enable  in  NLAYERS  channel may be granted when 1.
- cfg_timeout  in  TW  stall limit in cycles; 0 disables timeout.
- status_busy  out  1  frame in progress (state != IDLE).
- stat_frame_done  out  1  one-cycle pulse when an output tlast beat is accepted.
- stat_frame_layer  out  4  channel index of the last completed or aborted frame.
- stat_timeout  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: all outputs 0 (stat_frame_layer=0). FSM=IDLE, RR pointer=0, drop flags cleared, timeout counter=0.
- Output stage: single register. A new beat is loaded when !m_axis_tvalid || m_axis_tready. tvalid/tdata/tdest/tlast are held stable while tvalid && !tready. Input-to-output latency is 1 cycle. Full throughput of 1 beat/cycle within a frame.
- States:
  - IDLE: on the cycle any enabled, non-dropping channel has tvalid, grant the first such channel searching from RR pointer upward with wrap. Latch grant index. Go to DATA (or HDR when the option is built in). The grant costs one cycle; no input beat is consumed in IDLE.
  - DATA:
    - s_axis_tready[grant] = output stage can load; all other non-dropping channels see tready=0.
    - Each handshaked beat is copied out with tdest=LAYER_BASE+grant.
    - When a tlast beat is loaded, go to WAIT_LAST.
    - The timeout counter increments each cycle s_axis_tvalid[grant]=0 and clears on any valid cycle. When it reaches cfg_timeout (cfg_timeout != 0), go to ABORT.
    - Backpressure from m_axis_tready does not count toward the timeout.
  - ABORT: load beat ABORT_BYTE with tlast=1 when the output stage is free. Set drop[grant]. Pulse stat_timeout. Go to WAIT_LAST.
  - WAIT_LAST: when the tlast beat is accepted at the output, pulse stat_frame_done. Set stat_frame_layer=grant and RR pointer=grant+1 (wrap at NLAYERS). Go to IDLE.
- Drop flags:
  - While drop[i]=1, s_axis_tready[i]=1 and beats are discarded.
  - The flag clears on the handshake of a beat with tlast.
  - A dropping channel is never granted.
- Disabled channel: cfg_layer_enable[i]=0 keeps it out of arbitration and holds its tready low, except while it is dropping. Clearing the enable mid-frame does not affect the current frame.
- Simultaneous events:
  - A tlast beat arriving on the same cycle the timeout would fire wins; no abort occurs.
  - Enable changes take effect on the next IDLE decision.
- Single-beat frame (tlast on first beat): valid, produces one output beat.

Optional Feature:
- Macro LAYER_FRAMES_MUX_HEADER_EN.
- Defined: state HDR is inserted between IDLE and DATA. HDR emits one header beat {4'hA, grant[3:0]} with tlast=0 and the same tdest before the first data beat. Aborted frames keep their header.
- Undefined: HDR is absent; IDLE goes directly to DATA and output frames are byte-identical to the input frames.

Test Plan:
- NLAYERS=4, channels 0 and 2 each present a 3-byte frame simultaneously, tready=1 → ch0 frame out (tdest 0), then ch2 frame (tdest 2). Two stat_frame_done pulses; stat_frame_layer ends at 2.
- Ch1 sends continuous frames and ch3 has one pending → after ch1's frame, ch3 is granted before ch1 again.
- cfg_timeout=5, ch0 sends 2 bytes then drops tvalid for 5 cycles → output shows 2 bytes plus 8'hFF with tlast, and one stat_timeout pulse. Later ch0 beats up to tlast are discarded while ch0 tready is high. The next ch0 frame passes normally.
- Hold m_axis_tready=0 for 10 cycles mid-frame with cfg_timeout=3 → no abort; output beat held stable; stream resumes intact.
- cfg_layer_enable=4'b1011 with ch2 valid → ch2 tready stays 0 and is never granted; set bit 2 → ch2 frame is forwarded.
- Assert clk_core_rst mid-frame → all outputs 0 immediately; after release, a ch0 frame is granted first and forwarded intact.

Source files
------------

// File: rtl/layer_frames_mux_n.sv
// layer_frames_mux_n: frame-granular round-robin merge of NLAYERS 8-bit layer streams
//   onto one AXI-Stream output, each frame tagged with tdest = LAYER_BASE + channel.
// Latency 1 cycle (single output register), 1 beat/cycle within a frame; the grant costs 1 idle cycle.
// Backpressure: only the granted channel sees tready, and only when the output register can
//   load; a source stalling cfg_timeout cycles gets its frame closed with ABORT_BYTE+tlast and
//   its remaining beats up to tlast are accepted and discarded.
// Optional build macro LAYER_FRAMES_MUX_HEADER_EN: prepend a {4'hA, channel} header beat per frame.
// Ports: clk_core / clk_core_rst (async, active-high); s_axis_* per-layer inputs, channel i at
//   tdata[8i+7:8i]; m_axis_* merged output; cfg_layer_enable, cfg_timeout (0 = no timeout);
//   status_busy, stat_frame_done / stat_timeout pulses, stat_frame_layer.
module layer_frames_mux_n #(
    parameter int         NLAYERS    = 4,
    parameter int         LAYER_BASE = 0,
    parameter int         TW         = 16,
    parameter logic [7:0] ABORT_BYTE = 8'hFF
) (
    input  logic                 clk_core,
    input  logic                 clk_core_rst,
    input  logic [NLAYERS*8-1:0] s_axis_tdata,
    input  logic [NLAYERS-1:0]   s_axis_tlast,
    input  logic [NLAYERS-1:0]   s_axis_tvalid,
    output logic [NLAYERS-1:0]   s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic [7:0]           m_axis_tdest,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic [NLAYERS-1:0]   cfg_layer_enable,
    input  logic [TW-1:0]        cfg_timeout,
    output logic                 status_busy,
    output logic                 stat_frame_done,
    output logic [3:0]           stat_frame_layer,
    output logic                 stat_timeout
);
    localparam int IW = (NLAYERS > 1) ? $clog2(NLAYERS) : 1;

    typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA, ST_ABORT, ST_WAIT_LAST} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [NLAYERS-1:0] drop_q, drop_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [7:0]         tdata_q, tdata_d;
    logic [7:0]         tdest_q, tdest_d;
    logic               tlast_q, tlast_d;
    logic               tvalid_q, tvalid_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic [3:0]         layer_q, layer_d;

    logic               load_ok;
    logic [NLAYERS-1:0] cand;
    logic [NLAYERS-1:0] ready_c;
    logic               found;
    logic [IW-1:0]      pick;
    logic [IW:0]        ci;
    logic               g_vld;
    logic               g_lst;
    logic [7:0]         g_dat;
    logic [7:0]         g_dest;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        drop_d   = drop_q;
        tmo_d    = tmo_q;
        tdata_d  = tdata_q;
        tdest_d  = tdest_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        abort_d  = 1'b0;
        layer_d  = layer_q;
        found    = 1'b0;
        pick     = '0;
        ci       = '0;
        // dropping channels are always drained, whatever the FSM is doing
        ready_c  = drop_q;

        load_ok = !tvalid_q || m_axis_tready;
        cand    = s_axis_tvalid & cfg_layer_enable & ~drop_q;
        g_vld   = s_axis_tvalid[grant_q];
        g_lst   = s_axis_tlast[grant_q];
        g_dat   = s_axis_tdata[{grant_q, 3'b000} +: 8];
        g_dest  = 8'(LAYER_BASE) + 8'(grant_q);

        if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
        done_d = tvalid_q && tlast_q && m_axis_tready;

        for (int i = 0; i < NLAYERS; i++) begin
            if (drop_q[i] && s_axis_tvalid[i] && s_axis_tlast[i]) begin
                drop_d[i] = 1'b0;
            end
        end

        // first candidate at or above the round-robin pointer, wrapping at NLAYERS
        for (int k = 0; k < NLAYERS; k++) begin
            ci = {1'b0, rr_q} + (IW+1)'(k);
            if (ci >= (IW+1)'(NLAYERS)) begin
                ci = ci - (IW+1)'(NLAYERS);
            end
            if (!found && cand[ci[IW-1:0]]) begin
                found = 1'b1;
                pick  = ci[IW-1:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    tmo_d   = '0;
`ifdef LAYER_FRAMES_MUX_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_DATA;
`endif
                end
            end
`ifdef LAYER_FRAMES_MUX_HEADER_EN
            ST_HDR: begin
                if (load_ok) begin
                    tvalid_d = 1'b1;
                    tdata_d  = {4'hA, 4'(grant_q)};
                    tdest_d  = g_dest;
                    tlast_d  = 1'b0;
                    state_d  = ST_DATA;
                end
            end
`endif
            ST_DATA: begin
                ready_c[grant_q] = load_ok;
                if (g_vld) begin
                    // a valid source is never stalling, even if the sink is
                    tmo_d = '0;
                    if (load_ok) begin
                        tvalid_d = 1'b1;
                        tdata_d  = g_dat;
                        tdest_d  = g_dest;
                        tlast_d  = g_lst;
                        if (g_lst) begin
                            state_d = ST_WAIT_LAST;
                        end
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if ((cfg_timeout != '0) && (tmo_d >= cfg_timeout)) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_ABORT: begin
                if (load_ok) begin
                    tvalid_d         = 1'b1;
                    tdata_d          = ABORT_BYTE;
                    tdest_d          = g_dest;
                    tlast_d          = 1'b1;
                    drop_d[grant_q]  = 1'b1;
                    abort_d          = 1'b1;
                    tmo_d            = '0;
                    state_d          = ST_WAIT_LAST;
                end
            end
            ST_WAIT_LAST: begin
                // the register holds this frame's tlast beat; leave once it is taken
                if (done_d) begin
                    layer_d = 4'(grant_q);
                    if ({1'b0, grant_q} == (IW+1)'(NLAYERS - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = grant_q + IW'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_core or posedge clk_core_rst) begin
        if (clk_core_rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            drop_q   <= '0;
            tmo_q    <= '0;
            tdata_q  <= '0;
            tdest_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            layer_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            drop_q   <= drop_d;
            tmo_q    <= tmo_d;
            tdata_q  <= tdata_d;
            tdest_q  <= tdest_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            layer_q  <= layer_d;
        end
    end

    assign s_axis_tready    = ready_c;
    assign m_axis_tdata     = tdata_q;
    assign m_axis_tdest     = tdest_q;
    assign m_axis_tlast     = tlast_q;
    assign m_axis_tvalid    = tvalid_q;
    assign status_busy      = (state_q != ST_IDLE);
    assign stat_frame_done  = done_q;
    assign stat_frame_layer = layer_q;
    assign stat_timeout     = abort_q;
endmodule

// File: tb/tb_layer_frames_mux_n.sv
// tb_layer_frames_mux_n: directed scenarios plus a randomized multi-channel phase for
//   layer_frames_mux_n (NLAYERS=4, LAYER_BASE=0), output frames compared against
//   per-channel expected frame queues.
module tb_layer_frames_mux_n;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NL*8-1:0] s_axis_tdata;
    logic [NL-1:0]   s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic [7:0]      m_axis_tdata, m_axis_tdest;
    logic            m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [NL-1:0]   cfg_layer_enable;
    logic [15:0]     cfg_timeout;
    logic            status_busy, stat_frame_done, stat_timeout;
    logic [3:0]      stat_frame_layer;

    logic       tv [NL];
    logic       tl [NL];
    logic [7:0] td [NL];

    always_comb begin
        for (int i = 0; i < NL; i++) begin
            s_axis_tvalid[i]      = tv[i];
            s_axis_tlast[i]       = tl[i];
            s_axis_tdata[i*8 +: 8] = td[i];
        end
    end

    layer_frames_mux_n #(.NLAYERS(NL), .LAYER_BASE(0), .TW(16), .ABORT_BYTE(8'hFF)) dut (
        .clk_core(clk), .clk_core_rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tdest(m_axis_tdest),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .cfg_layer_enable(cfg_layer_enable), .cfg_timeout(cfg_timeout),
        .status_busy(status_busy), .stat_frame_done(stat_frame_done),
        .stat_frame_layer(stat_frame_layer), .stat_timeout(stat_timeout)
    );

    // output monitor: a beat is recorded at the negedge before the edge that accepts it
    logic [16:0] mon_arr [4096];
    int mon_wr = 0;
    int mon_rd = 0;
    int done_cnt = 0;
    int tmo_cnt = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                mon_arr[mon_wr & 4095] = {m_axis_tdest, m_axis_tlast, m_axis_tdata};
                mon_wr = mon_wr + 1;
            end
            if (stat_frame_done) done_cnt = done_cnt + 1;
            if (stat_timeout)    tmo_cnt  = tmo_cnt + 1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // present one sequence of beats on channel c; called at posedge+1
    task automatic send(input int c, input logic [7:0] bytes[$], input bit last,
                        input int gap_pct, output int ncyc);
        int waited;
        ncyc = 0;
        for (int j = 0; j < bytes.size(); j++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                tv[c] = 1'b0;
                repeat ($urandom_range(3, 1)) begin
                    @(posedge clk);
                    #1;
                    ncyc++;
                end
            end
            tv[c] = 1'b1;
            td[c] = bytes[j];
            tl[c] = last && (j == bytes.size() - 1);
            waited = 0;
            while (1) begin
                @(negedge clk);
                if (s_axis_tready[c]) break;
                waited++;
                if (waited > 300) begin
                    n_chk++;
                    n_err++;
                    $error("FAIL handshake_bound ch%0d beat%0d: waited=%0d cycles, required<=300", c, j, waited);
                    tv[c] = 1'b0;
                    tl[c] = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
                ncyc++;
            end
            @(posedge clk);
            #1;
            ncyc++;
        end
        tv[c] = 1'b0;
        tl[c] = 1'b0;
    endtask

    task automatic get_frame(output logic [7:0] d[$], output int dest, output int mixed);
        logic [16:0] b;
        d = {};
        dest = -1;
        mixed = 0;
        while (mon_rd != mon_wr) begin
            b = mon_arr[mon_rd & 4095];
            mon_rd++;
            if (dest < 0) dest = int'(b[16:9]);
            else if (int'(b[16:9]) != dest) mixed++;
            d.push_back(b[7:0]);
            if (b[8]) break;
        end
    endtask

    task automatic check_frame(input string tag, input int ch, input logic [7:0] e_in[$]);
        logic [7:0] e[$];
        logic [7:0] d[$];
        int dest, mixed;
        e = e_in;
`ifdef LAYER_FRAMES_MUX_HEADER_EN
        e.push_front({4'hA, 4'(ch)});
`endif
        get_frame(d, dest, mixed);
        chk({tag, " tdest"}, dest, ch);
        chk({tag, " len"}, d.size(), e.size());
        chk({tag, " mixed_dest"}, mixed, 0);
        for (int j = 0; j < e.size() && j < d.size(); j++)
            chk($sformatf("%s byte%0d", tag, j), d[j], e[j]);
    endtask

    logic [8:0] exp_flat [NL][$];
    logic [8:0] obs_flat [NL][$];

    task automatic rand_source(input int c);
        logic [7:0] q[$];
        logic [7:0] b;
        int len, n;
        for (int f = 0; f < 4; f++) begin
            len = $urandom_range(6, 1);
            q = {};
`ifdef LAYER_FRAMES_MUX_HEADER_EN
            exp_flat[c].push_back({1'b0, 4'hA, 4'(c)});
`endif
            for (int j = 0; j < len; j++) begin
                b = 8'($urandom);
                q.push_back(b);
                exp_flat[c].push_back({j == len - 1, b});
            end
            send(c, q, 1'b1, 30, n);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: no summary by time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] qa[$], qb[$], qc[$], qx[$];
        logic [7:0] d[$];
        int n0, n1, n3, nd, base_done, base_tmo, changes, rdy_hi, busy_hi;
        int dest, mixed, nfr, mixed_tot, bad_dest, mism;
        logic [17:0] snap;
        bit rdone;

        for (int i = 0; i < NL; i++) begin
            tv[i] = 1'b0;
            tl[i] = 1'b0;
            td[i] = 8'h00;
        end
        m_axis_tready    = 1'b1;
        cfg_layer_enable = 4'hF;
        cfg_timeout      = 16'd0;
        rst = 1'b1;
        cyc(3);

        // reset state
        chk("rst m_tvalid", m_axis_tvalid, 0);
        chk("rst m_tdata", m_axis_tdata, 0);
        chk("rst m_tdest", m_axis_tdest, 0);
        chk("rst m_tlast", m_axis_tlast, 0);
        chk("rst s_tready", s_axis_tready, 0);
        chk("rst busy", status_busy, 0);
        chk("rst frame_done", stat_frame_done, 0);
        chk("rst frame_layer", stat_frame_layer, 0);
        chk("rst timeout", stat_timeout, 0);
        rst = 1'b0;
        cyc(2);

        // T1: ch0 and ch2 simultaneous 3-byte frames
        base_done = done_cnt;
        qa = {8'd11, 8'd12, 8'd13};
        qb = {8'd21, 8'd22, 8'd23};
        fork
            send(0, qa, 1'b1, 0, n0);
            send(2, qb, 1'b1, 0, n1);
        join
        cyc(5);
        check_frame("T1 ch0", 0, qa);
        check_frame("T1 ch2", 2, qb);
        chk("T1 done pulses", done_cnt - base_done, 2);
        chk("T1 frame_layer", stat_frame_layer, 2);

        // T2: ch1 back-to-back frames, ch3 pending during the first one
        qa = {8'd41, 8'd42, 8'd43, 8'd44};
        qb = {8'd45, 8'd46};
        qc = {8'd47, 8'd48, 8'd49};
        fork
            begin
                send(1, qa, 1'b1, 0, n1);
                send(1, qb, 1'b1, 0, n1);
            end
            begin
                cyc(2);
                send(3, qc, 1'b1, 0, n3);
            end
        join
        cyc(5);
        check_frame("T2 ch1 first", 1, qa);
        check_frame("T2 ch3", 3, qc);
        check_frame("T2 ch1 second", 1, qb);
        chk("T2 frame_layer", stat_frame_layer, 1);

        // T3: timeout abort, discard of the remainder, then a clean frame
        cfg_timeout = 16'd5;
        base_done = done_cnt;
        base_tmo  = tmo_cnt;
        qa = {8'd31, 8'd32};
        send(0, qa, 1'b0, 0, n0);
        cyc(10);
        qx = {8'd31, 8'd32, 8'hFF};
        check_frame("T3 aborted", 0, qx);
        chk("T3 timeout pulses", tmo_cnt - base_tmo, 1);
        chk("T3 done pulses", done_cnt - base_done, 1);
        chk("T3 frame_layer", stat_frame_layer, 0);
        qb = {8'd33, 8'd34, 8'd35};
        send(0, qb, 1'b1, 0, n0);
        chk("T3 discard cycles", n0, 3);
        cyc(3);
        chk("T3 discard silent", mon_wr - mon_rd, 0);
        qc = {8'd36, 8'd37};
        send(0, qc, 1'b1, 0, n0);
        cyc(5);
        check_frame("T3 next", 0, qc);
        chk("T3 timeout total", tmo_cnt - base_tmo, 1);

        // T4: sink stall longer than the timeout does not abort
        cfg_timeout = 16'd3;
        base_tmo = tmo_cnt;
        qa = {8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56};
        fork
            send(2, qa, 1'b1, 0, n1);
            begin
                cyc(3);
                m_axis_tready = 1'b0;
                @(negedge clk);
                snap = {m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata};
                changes = 0;
                repeat (10) begin
                    @(negedge clk);
                    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdest, m_axis_tdata} !== snap) changes++;
                end
                @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        cyc(5);
        chk("T4 stalled valid", snap[17], 1);
        chk("T4 stall changes", changes, 0);
        chk("T4 no timeout", tmo_cnt - base_tmo, 0);
        check_frame("T4 ch2", 2, qa);

        // T5: disabled channel is neither ready nor granted until enabled
        cfg_layer_enable = 4'b1011;
        qa = {8'd61, 8'd62};
        fork
            send(2, qa, 1'b1, 0, n1);
            begin
                rdy_hi = 0;
                busy_hi = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (s_axis_tready[2]) rdy_hi++;
                    if (status_busy) busy_hi++;
                end
                @(posedge clk);
                #1;
                chk("T5 tready while disabled", rdy_hi, 0);
                chk("T5 busy while disabled", busy_hi, 0);
                chk("T5 nothing out", mon_wr - mon_rd, 0);
                cfg_layer_enable = 4'hF;
            end
        join
        cyc(5);
        check_frame("T5 ch2", 2, qa);

        // T6: reset in the middle of a frame
        tv[0] = 1'b1;
        td[0] = 8'd70;
        tl[0] = 1'b0;
        cyc(4);
        chk("T6 busy before reset", status_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("T6 outputs in reset",
            {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest, s_axis_tready,
             status_busy, stat_frame_done, stat_timeout}, 0);
        chk("T6 frame_layer in reset", stat_frame_layer, 0);
        tv[0] = 1'b0;
        cyc(2);
        rst = 1'b0;
        mon_rd = mon_wr;
        base_done = done_cnt;
        qa = {8'd71, 8'd72, 8'd73};
        qb = {8'd81};
        fork
            send(0, qa, 1'b1, 0, n0);
            send(3, qb, 1'b1, 0, n3);
        join
        cyc(5);
        check_frame("T6 ch0", 0, qa);
        check_frame("T6 ch3 single", 3, qb);
        chk("T6 done pulses", done_cnt - base_done, 2);
        chk("T6 frame_layer", stat_frame_layer, 3);

        // random phase: all channels, random source gaps and sink readiness
        cfg_timeout = 16'd0;
        rdone = 1'b0;
        fork
            begin
                fork
                    rand_source(0);
                    rand_source(1);
                    rand_source(2);
                    rand_source(3);
                join
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    m_axis_tready = ($urandom_range(99) < 70);
                    @(posedge clk);
                    #1;
                end
                m_axis_tready = 1'b1;
            end
        join
        cyc(20);
        nfr = 0;
        mixed_tot = 0;
        bad_dest = 0;
        while (mon_rd != mon_wr) begin
            get_frame(d, dest, mixed);
            nfr++;
            mixed_tot += mixed;
            if (dest < 0 || dest >= NL) bad_dest++;
            else for (int j = 0; j < d.size(); j++) obs_flat[dest].push_back({j == d.size() - 1, d[j]});
        end
        chk("RND frame count", nfr, 16);
        chk("RND interleaved", mixed_tot, 0);
        chk("RND bad tdest", bad_dest, 0);
        for (int c = 0; c < NL; c++) begin
            chk($sformatf("RND ch%0d beats", c), obs_flat[c].size(), exp_flat[c].size());
            mism = 0;
            for (int j = 0; j < exp_flat[c].size() && j < obs_flat[c].size(); j++)
                if (obs_flat[c][j] !== exp_flat[c][j]) mism++;
            chk($sformatf("RND ch%0d content", c), mism, 0);
        end
        chk("RND idle at end", status_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
